mem_access_unit: RTL and testbench
==================================

# mem_access_unit

Load/store sequencer for the MEM stage of the 16-bit CPU pipeline. It accepts one memory request per handshake from the EX/MEM register and drives the byte-addressed, big-endian data memory. The data memory samples on the falling clock edge, reads two bytes {mem[a], mem[a+1]} and writes when its write strobe is 1. The unit returns load results to write-back and performs read-modify-write for byte stores.

## Interface
- RD_W, 4: destination register index width.

- clk  in  1: pipeline clock; all unit state updates on posedge.
- reset  in  1: asynchronous, active-low; clears all state immediately.
- req_valid  in  1: request present.
- req_ready  out  1: unit can accept; high only in IDLE.
- req_load  in  1: request is a load.
- req_store  in  1: request is a store.
- req_byte  in  1: 1 = byte access, 0 = word access.
- req_signed  in  1: sign-extend a byte load; ignored otherwise.
- req_addr  in  16: byte address.
- req_wdata  in  16: store data; byte stores use bits [7:0].
- req_rd  in  RD_W: load destination register.
- mem_addr  out  16: data memory address.
- mem_wdata  out  16: data memory write data.
- mem_write  out  2: 2'b01 = write, 2'b00 = read; no other codes driven.
- mem_rdata  in  16: data memory read data, valid after the negedge of an access cycle.
- wb_valid  out  1: one-cycle pulse, load result present.
- wb_data  out  16: load result.
- wb_rd  out  RD_W: destination of wb_data.
- err  out  1: one-cycle pulse, request rejected.

## Operation
- States: IDLE, ACCESS, RMW_RD, RMW_WR.
- Accept: req_valid && req_ready at posedge. The unit latches the request, loads mem_addr, and selects the next state:
  - word store: mem_wdata = req_wdata, mem_write = 01 -> ACCESS.
  - load: mem_write = 00 -> ACCESS.
  - byte store: mem_write = 00 -> RMW_RD.
- ACCESS: memory acts at mid-cycle negedge. At the closing posedge:
  - load: capture mem_rdata, format it, pulse wb_valid, drive wb_rd -> IDLE.
  - store: mem_write returns to 00 -> IDLE.
- Load formatting:
  - word: wb_data = mem_rdata.
  - byte: wb_data = {8{s}, mem_rdata[15:8]}, with s = req_signed & mem_rdata[15].
- RMW_RD: at the closing posedge, hold the latched mem_rdata[7:0] (byte at addr+1). Drive mem_wdata = {st[7:0], held[7:0]} and mem_write = 01 -> RMW_WR.
- RMW_WR: the write occurs at negedge. At the closing posedge, mem_write returns to 00 -> IDLE.
- mem_rdata is never sampled in a cycle with mem_write = 01, because memory readout is undefined then.
- Rejections pulse err for one cycle, make no memory access and no wb_valid, and the unit stays IDLE:
  - word access with req_addr[0] = 1;
  - req_load && req_store.
- Accepted with neither load nor store: no-op, no pulse, stays IDLE.
- Byte access at 0xFFFF: RMW touches 0xFFFF and 0x0000, following memory wrap behaviour; it is not an error.
- wb_data and wb_rd hold their last value between pulses.

## Timing
- Reset values: req_ready = 1; mem_addr, mem_wdata, wb_data, wb_rd = 0; mem_write, wb_valid, err = 0; state = IDLE.
- Reset mid-operation forces mem_write = 00 asynchronously, so no write issues.
  - Interrupted RMW after RMW_RD: memory is left unmodified.
  - wb_valid is not issued for an aborted load.
- Load latency: accepted at posedge k; wb_valid high from k+1 to k+2.
- Word store occupancy: 1 cycle after accept.
- Byte store occupancy: 2 cycles after accept.
- Throughput:
  - one load or word store every 2 cycles;
  - one byte store every 3 cycles;
  - req_ready is 0 in every non-IDLE state.
- A new request may be accepted in the same cycle wb_valid is high.
- err is asserted in the cycle following the rejecting posedge.
- req_* must be held stable while req_valid && !req_ready; the unit latches only at accept.

## Test plan
- Reset, then word load at 0x0000 with memory pre-reset to 2B CD -> wb_valid one cycle after ACCESS, wb_data = 0x2BCD, wb_rd = req_rd.
- Word store 0x1234 at 0x0010, then word load 0x0010 -> wb_data = 0x1234.
- Byte store 0xAB at 0x0010, then word load 0x0010 -> 0xAB34.
- Byte load 0x0010, signed -> 0xFFAB; unsigned -> 0x00AB.
- Word load at 0x0011 -> err pulse, mem_write stays 00, no wb_valid, req_ready stays 1.
- Byte store 0x55 at 0x0020, with reset asserted in RMW_WR before the negedge -> mem_write drops to 00 immediately. A later load of 0x0020 returns the prior value; all outputs are at reset values.

Source files
------------

// File: rtl/mem_access_unit.sv
// mem_access_unit: load/store sequencer for the MEM stage of the 16-bit pipeline.
// Drives a big-endian, byte-addressed data memory that acts on the falling edge,
// returns formatted load results to write-back and performs read-modify-write
// for byte stores so the neighbouring byte of the 16-bit word is preserved.
module mem_access_unit #(
    parameter int RD_W = 4
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic            req_load,
    input  logic            req_store,
    input  logic            req_byte,
    input  logic            req_signed,
    input  logic [15:0]     req_addr,
    input  logic [15:0]     req_wdata,
    input  logic [RD_W-1:0] req_rd,
    output logic [15:0]     mem_addr,
    output logic [15:0]     mem_wdata,
    output logic [1:0]      mem_write,
    input  logic [15:0]     mem_rdata,
    output logic            wb_valid,
    output logic [15:0]     wb_data,
    output logic [RD_W-1:0] wb_rd,
    output logic            err
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RMW_RD = 2'd2,
        RMW_WR = 2'd3
    } state_t;

    localparam logic [1:0] MEM_RD = 2'b00;
    localparam logic [1:0] MEM_WR = 2'b01;

    state_t state;
    state_t state_next;

    logic [15:0]     mem_addr_next;
    logic [15:0]     mem_wdata_next;
    logic [1:0]      mem_write_next;
    logic            wb_valid_next;
    logic [15:0]     wb_data_next;
    logic [RD_W-1:0] wb_rd_next;
    logic            err_next;

    // Request fields kept from the accepting edge for the rest of the operation.
    logic            lat_load;
    logic            lat_byte;
    logic            lat_signed;
    logic [7:0]      lat_st;
    logic [RD_W-1:0] lat_rd;
    logic            lat_load_next;
    logic            lat_byte_next;
    logic            lat_signed_next;
    logic [7:0]      lat_st_next;
    logic [RD_W-1:0] lat_rd_next;

    logic            accept;
    logic            reject;
    logic [15:0]     load_fmt;

    assign req_ready = (state == IDLE);

    // Accept decode, rejection rules and load-result formatting.
    always_comb begin
        accept   = req_valid && (state == IDLE);
        reject   = accept && ((req_load && req_store) ||
                              ((req_load || req_store) && !req_byte && req_addr[0]));
        load_fmt = mem_rdata;
        if (lat_byte) begin
            load_fmt = {{8{lat_signed & mem_rdata[15]}}, mem_rdata[15:8]};
        end
    end

    // Next-state and next-output logic; every register holds unless changed below.
    always_comb begin
        state_next      = state;
        mem_addr_next   = mem_addr;
        mem_wdata_next  = mem_wdata;
        mem_write_next  = mem_write;
        wb_valid_next   = 1'b0;
        wb_data_next    = wb_data;
        wb_rd_next      = wb_rd;
        err_next        = 1'b0;
        lat_load_next   = lat_load;
        lat_byte_next   = lat_byte;
        lat_signed_next = lat_signed;
        lat_st_next     = lat_st;
        lat_rd_next     = lat_rd;

        case (state)
            IDLE: begin
                mem_write_next = MEM_RD;
                if (accept) begin
                    if (reject) begin
                        err_next = 1'b1;
                    end else if (req_load || req_store) begin
                        lat_load_next   = req_load;
                        lat_byte_next   = req_byte;
                        lat_signed_next = req_signed;
                        lat_st_next     = req_wdata[7:0];
                        lat_rd_next     = req_rd;
                        mem_addr_next   = req_addr;
                        if (req_load) begin
                            state_next = ACCESS;
                        end else if (req_byte) begin
                            state_next = RMW_RD;
                        end else begin
                            mem_wdata_next = req_wdata;
                            mem_write_next = MEM_WR;
                            state_next     = ACCESS;
                        end
                    end
                end
            end
            ACCESS: begin
                if (lat_load) begin
                    wb_valid_next = 1'b1;
                    wb_data_next  = load_fmt;
                    wb_rd_next    = lat_rd;
                end
                mem_write_next = MEM_RD;
                state_next     = IDLE;
            end
            RMW_RD: begin
                mem_wdata_next = {lat_st, mem_rdata[7:0]};
                mem_write_next = MEM_WR;
                state_next     = RMW_WR;
            end
            RMW_WR: begin
                mem_write_next = MEM_RD;
                state_next     = IDLE;
            end
            default: begin
                mem_write_next = MEM_RD;
                state_next     = IDLE;
            end
        endcase
    end

    // State register; reset returns to IDLE immediately.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Output and latched-request registers; reset drops mem_write at once so no write issues.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mem_addr   <= 16'h0000;
            mem_wdata  <= 16'h0000;
            mem_write  <= MEM_RD;
            wb_valid   <= 1'b0;
            wb_data    <= 16'h0000;
            wb_rd      <= '0;
            err        <= 1'b0;
            lat_load   <= 1'b0;
            lat_byte   <= 1'b0;
            lat_signed <= 1'b0;
            lat_st     <= 8'h00;
            lat_rd     <= '0;
        end else begin
            mem_addr   <= mem_addr_next;
            mem_wdata  <= mem_wdata_next;
            mem_write  <= mem_write_next;
            wb_valid   <= wb_valid_next;
            wb_data    <= wb_data_next;
            wb_rd      <= wb_rd_next;
            err        <= err_next;
            lat_load   <= lat_load_next;
            lat_byte   <= lat_byte_next;
            lat_signed <= lat_signed_next;
            lat_st     <= lat_st_next;
            lat_rd     <= lat_rd_next;
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit: table-driven bench for mem_access_unit with a falling-edge
// big-endian memory model and a write-back scoreboard, plus hand-written
// sequences for back-to-back loads and resets in the middle of an operation.
module tb_mem_access_unit;

    logic        clk;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic        req_load;
    logic        req_store;
    logic        req_byte;
    logic        req_signed;
    logic [15:0] req_addr;
    logic [15:0] req_wdata;
    logic [3:0]  req_rd;
    logic [15:0] mem_addr;
    logic [15:0] mem_wdata;
    logic [1:0]  mem_write;
    logic [15:0] mem_rdata;
    logic        wb_valid;
    logic [15:0] wb_data;
    logic [3:0]  wb_rd;
    logic        err;

    mem_access_unit #(.RD_W(4)) dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_load   (req_load),
        .req_store  (req_store),
        .req_byte   (req_byte),
        .req_signed (req_signed),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .req_rd     (req_rd),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_write  (mem_write),
        .mem_rdata  (mem_rdata),
        .wb_valid   (wb_valid),
        .wb_data    (wb_data),
        .wb_rd      (wb_rd),
        .err        (err)
    );

    // Field order: ld st byt sgn addr wdata rd | exp_wr exp_busy exp_err exp_wb exp_data
    typedef struct packed {
        logic        ld;
        logic        st;
        logic        byt;
        logic        sgn;
        logic [15:0] addr;
        logic [15:0] wdata;
        logic [3:0]  rd;
        logic [1:0]  exp_wr;
        logic [1:0]  exp_busy;
        logic        exp_err;
        logic        exp_wb;
        logic [15:0] exp_data;
    } vec_t;

    typedef struct packed {
        logic [15:0] data;
        logic [3:0]  rd;
    } wb_t;

    logic [7:0]  mem [0:65535];
    logic [15:0] addr_p1;
    wb_t         exp_q[$];
    vec_t        vecs [0:16];
    int          checks;
    int          passes;
    int          err_seen;
    int          wb_seen;

    assign addr_p1 = mem_addr + 16'd1;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) begin
            passes++;
        end else begin
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Data memory: acts on the falling edge; readout is garbage during a write.
    always @(negedge clk) begin
        if (mem_write == 2'b01) begin
            mem[mem_addr] <= mem_wdata[15:8];
            mem[addr_p1]  <= mem_wdata[7:0];
            mem_rdata     <= 16'hDEAD;
        end else begin
            mem_rdata <= {mem[mem_addr], mem[addr_p1]};
        end
    end

    // Write-back scoreboard and pulse counters, sampled away from the active edge.
    always @(negedge clk) begin
        if (reset && err) err_seen++;
        if (reset && wb_valid) begin
            wb_t e;
            wb_seen++;
            if (exp_q.size() == 0) begin
                check_output("wb_unexpected", 32'd1, 32'd0);
            end else begin
                e = exp_q.pop_front();
                check_output("wb_data", {16'h0, wb_data}, {16'h0, e.data});
                check_output("wb_rd", {28'h0, wb_rd}, {28'h0, e.rd});
            end
        end
    end

    task automatic wait_ready();
        int guard;
        guard = 0;
        @(negedge clk);
        while (!req_ready && guard < 20) begin
            guard++;
            @(negedge clk);
        end
        if (!req_ready) check_output("ready_timeout", 32'd0, 32'd1);
    endtask

    task automatic drive(input vec_t v);
        req_load   = v.ld;
        req_store  = v.st;
        req_byte   = v.byt;
        req_signed = v.sgn;
        req_addr   = v.addr;
        req_wdata  = v.wdata;
        req_rd     = v.rd;
        req_valid  = 1'b1;
        if (v.exp_wb) exp_q.push_back('{v.exp_data, v.rd});
    endtask

    task automatic apply_stimulus(input vec_t v, input int idx);
        int busy;
        int e0;
        int w0;
        wait_ready();
        e0 = err_seen;
        w0 = wb_seen;
        drive(v);
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        check_output($sformatf("v%0d_mem_write", idx), {30'h0, mem_write}, {30'h0, v.exp_wr});
        busy = 0;
        while (!req_ready && busy < 8) begin
            busy++;
            @(negedge clk);
        end
        check_output($sformatf("v%0d_busy", idx), busy, {30'h0, v.exp_busy});
        repeat (2) @(negedge clk);
        check_output($sformatf("v%0d_err", idx), err_seen - e0, {31'h0, v.exp_err});
        check_output($sformatf("v%0d_wb", idx), wb_seen - w0, {31'h0, v.exp_wb});
    endtask

    task automatic check_reset_outputs(input string tag);
        check_output({tag, "_ready"}, {31'h0, req_ready}, 32'd1);
        check_output({tag, "_mem_write"}, {30'h0, mem_write}, 32'd0);
        check_output({tag, "_mem_addr"}, {16'h0, mem_addr}, 32'd0);
        check_output({tag, "_mem_wdata"}, {16'h0, mem_wdata}, 32'd0);
        check_output({tag, "_wb_valid"}, {31'h0, wb_valid}, 32'd0);
        check_output({tag, "_wb_data"}, {16'h0, wb_data}, 32'd0);
        check_output({tag, "_wb_rd"}, {28'h0, wb_rd}, 32'd0);
        check_output({tag, "_err"}, {31'h0, err}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL global_timeout: simulation did not finish");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        vec_t v;
        int   w0;
        checks = 0; passes = 0; err_seen = 0; wb_seen = 0;
        for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
        mem[16'h0000] = 8'h2B; mem[16'h0001] = 8'hCD;
        mem[16'h0020] = 8'h11; mem[16'h0021] = 8'h22;

        vecs[0]  = '{1'b1,1'b0,1'b0,1'b0,16'h0000,16'h0000,4'd3, 2'b00,2'd1,1'b0,1'b1,16'h2BCD};
        vecs[1]  = '{1'b0,1'b1,1'b0,1'b0,16'h0010,16'h1234,4'd0, 2'b01,2'd1,1'b0,1'b0,16'h0000};
        vecs[2]  = '{1'b1,1'b0,1'b0,1'b0,16'h0010,16'h0000,4'd5, 2'b00,2'd1,1'b0,1'b1,16'h1234};
        vecs[3]  = '{1'b0,1'b1,1'b1,1'b0,16'h0010,16'h77AB,4'd0, 2'b00,2'd2,1'b0,1'b0,16'h0000};
        vecs[4]  = '{1'b1,1'b0,1'b0,1'b0,16'h0010,16'h0000,4'd6, 2'b00,2'd1,1'b0,1'b1,16'hAB34};
        vecs[5]  = '{1'b1,1'b0,1'b1,1'b1,16'h0010,16'h0000,4'd7, 2'b00,2'd1,1'b0,1'b1,16'hFFAB};
        vecs[6]  = '{1'b1,1'b0,1'b1,1'b0,16'h0010,16'h0000,4'd8, 2'b00,2'd1,1'b0,1'b1,16'h00AB};
        vecs[7]  = '{1'b1,1'b0,1'b0,1'b0,16'h0011,16'h0000,4'd9, 2'b00,2'd0,1'b1,1'b0,16'h0000};
        vecs[8]  = '{1'b1,1'b1,1'b0,1'b0,16'h0010,16'h5555,4'd9, 2'b00,2'd0,1'b1,1'b0,16'h0000};
        vecs[9]  = '{1'b0,1'b0,1'b0,1'b0,16'h0010,16'h9999,4'd9, 2'b00,2'd0,1'b0,1'b0,16'h0000};
        vecs[10] = '{1'b0,1'b1,1'b1,1'b0,16'h0011,16'h1180,4'd0, 2'b00,2'd2,1'b0,1'b0,16'h0000};
        vecs[11] = '{1'b1,1'b0,1'b0,1'b0,16'h0010,16'h0000,4'd9, 2'b00,2'd1,1'b0,1'b1,16'hAB80};
        vecs[12] = '{1'b1,1'b0,1'b1,1'b1,16'h0011,16'h0000,4'd10,2'b00,2'd1,1'b0,1'b1,16'hFF80};
        vecs[13] = '{1'b0,1'b1,1'b1,1'b0,16'hFFFF,16'h00C3,4'd0, 2'b00,2'd2,1'b0,1'b0,16'h0000};
        vecs[14] = '{1'b1,1'b0,1'b1,1'b0,16'hFFFF,16'h0000,4'd11,2'b00,2'd1,1'b0,1'b1,16'h00C3};
        vecs[15] = '{1'b1,1'b0,1'b0,1'b0,16'h0000,16'h0000,4'd12,2'b00,2'd1,1'b0,1'b1,16'h2BCD};
        vecs[16] = '{1'b1,1'b0,1'b1,1'b1,16'h0000,16'h0000,4'd13,2'b00,2'd1,1'b0,1'b1,16'h002B};

        reset = 1'b0; req_valid = 1'b0; req_load = 1'b0; req_store = 1'b0;
        req_byte = 1'b0; req_signed = 1'b0; req_addr = 16'h0; req_wdata = 16'h0; req_rd = 4'h0;
        #3;
        check_reset_outputs("por");
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;

        $display("[TB] table vectors");
        for (int i = 0; i < 17; i++) apply_stimulus(vecs[i], i);

        $display("[TB] back-to-back loads");
        wait_ready();
        v = '{1'b1,1'b0,1'b0,1'b0,16'h0010,16'h0000,4'd14,2'b00,2'd1,1'b0,1'b1,16'hAB80};
        drive(v);
        @(posedge clk);
        @(negedge clk);
        v = '{1'b1,1'b0,1'b1,1'b0,16'h0011,16'h0000,4'd15,2'b00,2'd1,1'b0,1'b1,16'h0080};
        drive(v);
        check_output("b2b_busy", {31'h0, req_ready}, 32'd0);
        @(negedge clk);
        check_output("b2b_ready", {31'h0, req_ready}, 32'd1);
        check_output("b2b_wb_overlap", {31'h0, wb_valid}, 32'd1);
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        repeat (4) @(negedge clk);
        check_output("b2b_queue_empty", exp_q.size(), 32'd0);
        check_output("wb_data_hold", {16'h0, wb_data}, 32'h0080);
        check_output("wb_rd_hold", {28'h0, wb_rd}, 32'd15);

        $display("[TB] reset during load access");
        wait_ready();
        w0 = wb_seen;
        req_load = 1'b1; req_store = 1'b0; req_byte = 1'b0; req_addr = 16'h0000; req_rd = 4'd1;
        req_valid = 1'b1;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        reset = 1'b0;
        #1;
        check_reset_outputs("abort_ld");
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        repeat (3) @(negedge clk);
        check_output("abort_ld_no_wb", wb_seen - w0, 32'd0);

        $display("[TB] reset during byte-store write phase");
        wait_ready();
        req_load = 1'b0; req_store = 1'b1; req_byte = 1'b1; req_signed = 1'b0;
        req_addr = 16'h0020; req_wdata = 16'h0055; req_rd = 4'd0;
        req_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        @(posedge clk);
        #1;
        check_output("rmw_wr_active", {30'h0, mem_write}, 32'd1);
        reset = 1'b0;
        #1;
        check_reset_outputs("abort_rmw");
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        check_output("abort_rmw_mem", {16'h0, mem[16'h0020], mem[16'h0021]}, 32'h1122);
        v = '{1'b1,1'b0,1'b0,1'b0,16'h0020,16'h0000,4'd2,2'b00,2'd1,1'b0,1'b1,16'h1122};
        apply_stimulus(v, 99);
        check_output("final_queue_empty", exp_q.size(), 32'd0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
